// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-redirect bundle: EX/BPU/CSR/stall inputs toward the controller and fetch outputs back.
// The master drives redirect and stall requests; the slave is the fetch PC sequencer.
interface fetch_redirect_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            Branch_Taken__EX_MEM;
    logic [XLEN-1:0] Branch_Target_Addr__EX_MEM;
    logic            bpu_taken;
    logic [XLEN-1:0] bpu_target;
    logic            trap_req;
    logic [1:0]      trap_cause;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            load_stall;
    logic            freeze;
    logic            fetch_ready;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            if_id_nop;
    logic            trap_ack;
    logic            busy;

    modport master (
        output Branch_Taken__EX_MEM, Branch_Target_Addr__EX_MEM, bpu_taken, bpu_target,
               trap_req, trap_cause, csr_mtvec, csr_mepc, load_stall, freeze, fetch_ready,
        input  pc, pc_valid, if_id_nop, trap_ack, busy
    );

    modport slave (
        input  Branch_Taken__EX_MEM, Branch_Target_Addr__EX_MEM, bpu_taken, bpu_target,
               trap_req, trap_cause, csr_mtvec, csr_mepc, load_stall, freeze, fetch_ready,
        output pc, pc_valid, if_id_nop, trap_ack, busy
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: sequential / BPU / EX redirect selection, plus a drain-then-redirect
// path for trap entry and mret. All outputs come straight from registers.
module fetch_redirect_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = {XLEN{1'b0}},
    parameter int unsigned     DRAIN_CYCLES = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    fetch_redirect_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e           state_r;
    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  pend_target_r;
    logic             pend_vld_r;
    logic             pc_valid_r;
    logic             if_id_nop_r;
    logic             trap_ack_r;
    logic             busy_r;
    logic [CNT_W-1:0] drain_cnt_r;
    logic [XLEN-1:0]  pc_inc_s;
    logic [XLEN-1:0]  trap_target_s;

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    assign pc_inc_s      = pc_r + {{(XLEN-3){1'b0}}, 3'b100};
    assign trap_target_s = align4((bus.trap_cause == 2'd3) ? bus.csr_mepc : bus.csr_mtvec);

    assign bus.pc        = pc_r;
    assign bus.pc_valid  = pc_valid_r;
    assign bus.if_id_nop = if_id_nop_r;
    assign bus.trap_ack  = trap_ack_r;
    assign bus.busy      = busy_r;

    // Redirect FSM and every registered fetch output.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            pend_target_r <= {XLEN{1'b0}};
            pend_vld_r    <= 1'b0;
            pc_valid_r    <= 1'b0;
            if_id_nop_r   <= 1'b1;
            trap_ack_r    <= 1'b0;
            busy_r        <= 1'b0;
            drain_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    trap_ack_r <= 1'b0;
                    if (bus.trap_req) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= CNT_W'(DRAIN_CYCLES - 1);
                        pend_vld_r  <= 1'b0;
                        pc_valid_r  <= 1'b0;
                        if_id_nop_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        pc_valid_r <= 1'b1;
                        if (bus.Branch_Taken__EX_MEM) begin
                            if_id_nop_r <= 1'b1;
                            if (bus.freeze) begin
                                pend_target_r <= align4(bus.Branch_Target_Addr__EX_MEM);
                                pend_vld_r    <= 1'b1;
                            end else begin
                                pc_r       <= align4(bus.Branch_Target_Addr__EX_MEM);
                                pend_vld_r <= 1'b0;
                            end
                        end else if (pend_vld_r && !bus.freeze) begin
                            pc_r        <= pend_target_r;
                            pend_vld_r  <= 1'b0;
                            if_id_nop_r <= 1'b1;
                        end else if (!pc_valid_r) begin
                            // First cycle out of reset: RESET_PC has not been fetched yet.
                            if_id_nop_r <= 1'b1;
                        end else if (bus.freeze || bus.load_stall || !bus.fetch_ready) begin
                            if_id_nop_r <= bus.load_stall;
                        end else if (bus.bpu_taken) begin
                            pc_r        <= align4(bus.bpu_target);
                            if_id_nop_r <= 1'b0;
                        end else begin
                            pc_r        <= pc_inc_s;
                            if_id_nop_r <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == {CNT_W{1'b0}}) begin
                        state_r    <= ST_REDIRECT;
                        pc_r       <= trap_target_s;
                        trap_ack_r <= 1'b1;
                        pc_valid_r <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - CNT_W'(1);
                    end
                end
                ST_REDIRECT: begin
                    // The vector/return address is being fetched now; resume sequencing.
                    state_r     <= ST_RUN;
                    trap_ack_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    if_id_nop_r <= !bus.fetch_ready;
                    if (bus.fetch_ready) begin
                        pc_r <= bus.bpu_taken ? align4(bus.bpu_target) : pc_inc_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    trap_ack_r <= 1'b0;
                    busy_r     <= 1'b0;
                    pend_vld_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table, trap sequences, then random
// stimulus against a behavioural model built from the redirect priority rules.
module tb_fetch_redirect_ctrl;
    localparam int          DRAIN    = 3;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    fetch_redirect_ctrl_if #(.XLEN(32)) bus ();

    fetch_redirect_ctrl #(
        .XLEN(32), .RESET_PC(RESET_PC), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        br;
        logic [31:0] br_tgt;
        logic        bpu;
        logic [31:0] bpu_tgt;
        logic        frz;
        logic        ls;
        logic        rdy;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_nop;
    } vec_t;

    vec_t vecs[20];

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_nop;
    logic        m_ack;
    int          m_left;
    logic [31:0] pend_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        bus.Branch_Taken__EX_MEM       = 1'b0;
        bus.Branch_Target_Addr__EX_MEM = 32'h0;
        bus.bpu_taken                  = 1'b0;
        bus.bpu_target                 = 32'h0;
        bus.trap_req                   = 1'b0;
        bus.trap_cause                 = 2'd0;
        bus.csr_mtvec                  = 32'h0;
        bus.csr_mepc                   = 32'h0;
        bus.load_stall                 = 1'b0;
        bus.freeze                     = 1'b0;
        bus.fetch_ready                = 1'b1;
    endtask

    function automatic logic [31:0] al(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_valid = 1'b0;
        m_nop   = 1'b1;
        m_ack   = 1'b0;
        m_left  = 0;
        pend_q.delete();
    endtask

    // One clock edge of the reference model, using the inputs as they stood before the edge.
    task automatic model_step();
        logic was_valid;
        if (!RST_N) begin
            model_reset();
        end else if (m_ack) begin
            m_ack   = 1'b0;
            m_valid = 1'b1;
            m_nop   = !bus.fetch_ready;
            if (bus.fetch_ready) m_pc = bus.bpu_taken ? al(bus.bpu_target) : m_pc + 32'd4;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_pc    = al((bus.trap_cause == 2'd3) ? bus.csr_mepc : bus.csr_mtvec);
                m_ack   = 1'b1;
                m_valid = 1'b1;
            end
        end else if (bus.trap_req) begin
            m_left  = DRAIN;
            m_valid = 1'b0;
            m_nop   = 1'b1;
            pend_q.delete();
        end else begin
            was_valid = m_valid;
            m_valid   = 1'b1;
            if (bus.Branch_Taken__EX_MEM) begin
                m_nop = 1'b1;
                pend_q.delete();
                if (bus.freeze) pend_q.push_back(al(bus.Branch_Target_Addr__EX_MEM));
                else m_pc = al(bus.Branch_Target_Addr__EX_MEM);
            end else if (pend_q.size() > 0 && !bus.freeze) begin
                m_pc  = pend_q.pop_front();
                m_nop = 1'b1;
            end else if (!was_valid) begin
                m_nop = 1'b1;
            end else if (bus.freeze || bus.load_stall || !bus.fetch_ready) begin
                m_nop = bus.load_stall;
            end else begin
                m_pc  = bus.bpu_taken ? al(bus.bpu_target) : m_pc + 32'd4;
                m_nop = 1'b0;
            end
        end
    endtask

    task automatic trap_seq(input string name, input logic [1:0] cause, input logic [31:0] vec,
                            input logic [31:0] epc, input logic with_br, input logic [31:0] exp_pc);
        int acks;
        int bubbles;
        int ack_at;
        acks    = 0;
        bubbles = 0;
        ack_at  = -1;
        set_idle();
        bus.trap_req                   = 1'b1;
        bus.trap_cause                 = cause;
        bus.csr_mtvec                  = vec;
        bus.csr_mepc                   = epc;
        bus.Branch_Taken__EX_MEM       = with_br;
        bus.Branch_Target_Addr__EX_MEM = 32'h0000_0700;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.Branch_Taken__EX_MEM = 1'b0;
            if (bus.trap_ack) begin
                acks++;
                if (ack_at < 0) begin
                    ack_at = i;
                    chk({name, "_pc"}, bus.pc, exp_pc);
                    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
                end
                bus.trap_req = 1'b0;
            end else if (ack_at < 0) begin
                if (!bus.pc_valid) bubbles++;
            end else if (i == ack_at + 1) begin
                chk({name, "_next_pc"}, bus.pc, exp_pc + 32'd4);
                chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
            end
        end
        bus.trap_req = 1'b0;
        chk({name, "_acks"}, acks, 32'd1);
        chk({name, "_bubbles"}, bubbles, DRAIN);
        chk({name, "_latency"}, ack_at, DRAIN);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 32'h13, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h200,      1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0204, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_0204, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0000_0204, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h300,      1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0000_0204, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0000_0204, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0304, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 32'h400,      1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0000_0304, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 32'h503,      1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0000_0304, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0504, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 32'hFFFFFFFA, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        set_idle();
        RST_N = 1'b0;
        tick();
        tick();
        chk("reset_pc", bus.pc, RESET_PC);
        chk("reset_valid", {31'd0, bus.pc_valid}, 32'd0);
        chk("reset_nop", {31'd0, bus.if_id_nop}, 32'd1);
        chk("reset_ack", {31'd0, bus.trap_ack}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        RST_N = 1'b1;

        for (int i = 0; i < 20; i++) begin
            bus.Branch_Taken__EX_MEM       = vecs[i].br;
            bus.Branch_Target_Addr__EX_MEM = vecs[i].br_tgt;
            bus.bpu_taken                  = vecs[i].bpu;
            bus.bpu_target                 = vecs[i].bpu_tgt;
            bus.freeze                     = vecs[i].frz;
            bus.load_stall                 = vecs[i].ls;
            bus.fetch_ready                = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_pc", i), bus.pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.pc_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_nop", i), {31'd0, bus.if_id_nop}, {31'd0, vecs[i].exp_nop});
            chk($sformatf("vec%0d_busy", i), {31'd0, bus.busy | bus.trap_ack}, 32'd0);
        end

        trap_seq("trap_ecall", 2'd1, 32'h0000_0080, 32'h0000_0900, 1'b0, 32'h0000_0080);
        trap_seq("trap_mret", 2'd3, 32'h0000_0080, 32'h0000_1236, 1'b1, 32'h0000_1234);

        // Reset arriving mid-drain
        set_idle();
        bus.trap_req   = 1'b1;
        bus.trap_cause = 2'd2;
        bus.csr_mtvec  = 32'h0000_0440;
        tick();
        tick();
        chk("drain_busy", {31'd0, bus.busy}, 32'd1);
        RST_N = 1'b0;
        tick();
        bus.trap_req = 1'b0;
        chk("rst_drain_pc", bus.pc, RESET_PC);
        chk("rst_drain_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_drain_ack", {31'd0, bus.trap_ack}, 32'd0);
        RST_N = 1'b1;
        tick();
        chk("rst_drain_valid", {31'd0, bus.pc_valid}, 32'd1);
        tick();
        chk("rst_drain_noack", {31'd0, bus.trap_ack}, 32'd0);
        chk("rst_drain_pc4", bus.pc, RESET_PC + 32'd4);

        // Randomised run against the reference model
        set_idle();
        RST_N = 1'b0;
        tick();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            RST_N                          = ($urandom_range(199) != 0);
            bus.Branch_Taken__EX_MEM       = ($urandom_range(7) == 0);
            bus.Branch_Target_Addr__EX_MEM = $urandom;
            bus.bpu_taken                  = ($urandom_range(3) == 0);
            bus.bpu_target                 = $urandom;
            bus.freeze                     = ($urandom_range(5) == 0);
            bus.load_stall                 = ($urandom_range(7) == 0);
            bus.fetch_ready                = ($urandom_range(4) != 0);
            if (!RST_N || (bus.trap_req && m_ack)) begin
                bus.trap_req = 1'b0;
            end else if (!bus.trap_req && $urandom_range(24) == 0) begin
                bus.trap_req   = 1'b1;
                bus.trap_cause = 2'($urandom_range(3));
                bus.csr_mtvec  = $urandom;
                bus.csr_mepc   = $urandom;
            end
            tick();
            model_step();
            chk("rnd_pc", bus.pc, m_pc);
            chk("rnd_valid", {31'd0, bus.pc_valid}, {31'd0, m_valid});
            chk("rnd_nop", {31'd0, bus.if_id_nop}, {31'd0, m_nop});
            chk("rnd_ack", {31'd0, bus.trap_ack}, {31'd0, m_ack});
            chk("rnd_busy", {31'd0, bus.busy}, {31'd0, (m_left > 0) || m_ack});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
